// File: rtl/wb_cmd_master_if.sv
// Bundle of the command stream, response stream and Wishbone master-side
// signals. Modport "master" is the view taken by wb_cmd_master; modport
// "slave" is the view of whatever drives commands and models the bus.
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid and ready are both high; once valid is high, the payload stays stable
// and valid stays high until that transfer edge.
interface wb_cmd_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Command stream.
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_we;
    logic [AW-1:0]   cmd_adr;
    logic [DW-1:0]   cmd_dat;
    logic [DW/8-1:0] cmd_sel;

    // Response stream.
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_dat;
    logic [1:0]      rsp_status;

    // Wishbone master signals.
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            wb_rty_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_status,
        input  rsp_ready,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_status,
        output rsp_ready,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone B3 classic master. Each accepted command runs
// one bus cycle (re-issued after rty up to MAX_RETRIES times, bounded by
// TIMEOUT_CYCLES per attempt) and produces exactly one response.
// dbg_state exposes the FSM state: 0 IDLE, 1 BUS, 2 GAP, 3 RESP.
module wb_cmd_master #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    wb_cmd_master_if.master      bus,
    output logic [1:0]           dbg_state
);
    // Keep counters at least one bit wide so a zero parameter still elaborates.
    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [RT_W-1:0] RT_LIMIT = RT_W'(MAX_RETRIES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_ERR     = 2'd1,
        ST_RETRY   = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_e;

    state_e          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [DW/8-1:0] sel_q, sel_d;
    logic [DW-1:0]   rsp_dat_q, rsp_dat_d;
    logic [1:0]      rsp_status_q, rsp_status_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [RT_W-1:0] rty_cnt_q, rty_cnt_d;

    // State and datapath registers; reset clears everything to the idle bus.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q      <= IDLE;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            rsp_dat_q    <= '0;
            rsp_status_q <= 2'd0;
            to_cnt_q     <= '0;
            rty_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            to_cnt_q     <= to_cnt_d;
            rty_cnt_q    <= rty_cnt_d;
        end
    end

    // Next-state logic; terminations are only looked at in BUS, err > ack > rty.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        to_cnt_d     = to_cnt_q;
        rty_cnt_d    = rty_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d   = BUS;
                    cyc_d     = 1'b1;
                    we_d      = bus.cmd_we;
                    adr_d     = bus.cmd_adr;
                    dat_d     = bus.cmd_dat;
                    sel_d     = bus.cmd_sel;
                    to_cnt_d  = '0;
                    rty_cnt_d = '0;
                end
            end
            BUS: begin
                if (bus.wb_err_i) begin
                    state_d      = RESP;
                    cyc_d        = 1'b0;
                    rsp_status_d = ST_ERR;
                    rsp_dat_d    = '0;
                end else if (bus.wb_ack_i) begin
                    state_d      = RESP;
                    cyc_d        = 1'b0;
                    rsp_status_d = ST_OK;
                    rsp_dat_d    = we_q ? '0 : bus.wb_dat_i;
                end else if (bus.wb_rty_i) begin
                    cyc_d = 1'b0;
                    if (rty_cnt_q < RT_LIMIT) begin
                        state_d   = GAP;
                        rty_cnt_d = rty_cnt_q + 1'b1;
                    end else begin
                        state_d      = RESP;
                        rsp_status_d = ST_RETRY;
                        rsp_dat_d    = '0;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LIMIT)) begin
                    state_d      = RESP;
                    cyc_d        = 1'b0;
                    rsp_status_d = ST_TIMEOUT;
                    rsp_dat_d    = '0;
                end else if (!(&to_cnt_q)) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            GAP: begin
                state_d  = BUS;
                cyc_d    = 1'b1;
                to_cnt_d = '0;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // Outputs are registers or decodes of the registered state only.
    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_dat    = rsp_dat_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.wb_cyc_o   = cyc_q;
    assign bus.wb_stb_o   = cyc_q;
    assign bus.wb_we_o    = we_q;
    assign bus.wb_adr_o   = adr_q;
    assign bus.wb_dat_o   = dat_q;
    assign bus.wb_sel_o   = sel_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with TIMEOUT_CYCLES = 5, MAX_RETRIES = 3.
// The bench plays both the command source and the Wishbone slave, stepping
// cycle by cycle; inputs change and outputs are sampled 1 ns after posedge.
module tb_wb_cmd_master;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic       wb_clk = 1'b0;
    logic       wb_rst = 1'b1;
    logic [1:0] dbg_state;
    int         n_vec = 0;
    int         n_err = 0;

    wb_cmd_master_if #(.AW(32), .DW(32)) bus ();

    wb_cmd_master #(
        .AW(32), .DW(32), .TIMEOUT_CYCLES(5), .MAX_RETRIES(3)
    ) dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // Clock and reset block.
    always #5 wb_clk = ~wb_clk;

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents a command in the current (IDLE) cycle and returns in BUS cycle 1.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        check("cmd_ready_before_accept", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Single-cycle slave termination in the current cycle.
    task automatic term(input logic ack, input logic err, input logic rty, input logic [31:0] d);
        bus.wb_ack_i = ack;
        bus.wb_err_i = err;
        bus.wb_rty_i = rty;
        bus.wb_dat_i = d;
        tick();
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_rty_i = 1'b0;
        bus.wb_dat_i = 32'h0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h0;
        bus.cmd_dat   = 32'h0;
        bus.cmd_sel   = 4'h0;
        bus.rsp_ready = 1'b1;
        bus.wb_dat_i  = 32'h0;
        bus.wb_ack_i  = 1'b0;
        bus.wb_err_i  = 1'b0;
        bus.wb_rty_i  = 1'b0;

        // Reset values.
        #2;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_cyc", bus.wb_cyc_o, 0);
        check("rst_stb", bus.wb_stb_o, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_state", dbg_state, S_IDLE);
        tick();
        tick();
        wb_rst = 1'b0;

        // Termination inputs while IDLE are ignored.
        term(1'b1, 1'b1, 1'b1, 32'h1111_2222);
        check("idle_term_state", dbg_state, S_IDLE);
        check("idle_term_rsp_valid", bus.rsp_valid, 0);

        // Read, registered ack (ack in cycle 2), response in cycle 3.
        issue(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        check("rd_c1_cyc", bus.wb_cyc_o, 1);
        check("rd_c1_stb", bus.wb_stb_o, 1);
        check("rd_c1_we", bus.wb_we_o, 0);
        check("rd_c1_adr", bus.wb_adr_o, 32'h0000_0010);
        check("rd_c1_cmd_ready", bus.cmd_ready, 0);
        tick();
        check("rd_c2_cyc", bus.wb_cyc_o, 1);
        term(1'b1, 1'b0, 1'b0, 32'h0C0B_000A);
        check("rd_c3_cyc", bus.wb_cyc_o, 0);
        check("rd_c3_rsp_valid", bus.rsp_valid, 1);
        check("rd_c3_rsp_dat", bus.rsp_dat, 32'h0C0B_000A);
        check("rd_c3_status", bus.rsp_status, 0);
        tick();
        check("rd_c4_rsp_valid", bus.rsp_valid, 0);
        check("rd_c4_cmd_ready", bus.cmd_ready, 1);

        // Write: address/data/select/we held for the whole cycle.
        issue(1'b1, 32'h0000_0008, 32'hA5A5_5A5A, 4'h1);
        bus.cmd_adr = 32'hFFFF_FFFF;
        bus.cmd_dat = 32'h0;
        bus.cmd_sel = 4'hE;
        bus.cmd_we  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check("wr_we", bus.wb_we_o, 1);
            check("wr_adr", bus.wb_adr_o, 32'h0000_0008);
            check("wr_dat", bus.wb_dat_o, 32'hA5A5_5A5A);
            check("wr_sel", bus.wb_sel_o, 4'h1);
            if (c == 0) tick();
        end
        term(1'b1, 1'b0, 1'b0, 32'hDEAD_0000);
        check("wr_rsp_valid", bus.rsp_valid, 1);
        check("wr_status", bus.rsp_status, 0);
        check("wr_rsp_dat", bus.rsp_dat, 0);
        tick();

        // Three rty, then ack: four BUS phases with one-cycle gaps, status OK.
        issue(1'b0, 32'h0000_0020, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            check("rty3_bus_cyc", bus.wb_cyc_o, 1);
            check("rty3_bus_adr", bus.wb_adr_o, 32'h0000_0020);
            term(1'b0, 1'b0, 1'b1, 32'h0);
            check("rty3_gap_cyc", bus.wb_cyc_o, 0);
            check("rty3_gap_state", dbg_state, S_GAP);
            tick();
        end
        check("rty3_last_bus_cyc", bus.wb_cyc_o, 1);
        term(1'b1, 1'b0, 1'b0, 32'h0000_1234);
        check("rty3_rsp_valid", bus.rsp_valid, 1);
        check("rty3_status", bus.rsp_status, 0);
        check("rty3_rsp_dat", bus.rsp_dat, 32'h0000_1234);
        tick();

        // Four rty: retries exhausted, status RETRY after the fourth.
        issue(1'b0, 32'h0000_0024, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            check("rty4_bus_cyc", bus.wb_cyc_o, 1);
            term(1'b0, 1'b0, 1'b1, 32'h0);
            if (k < 3) begin
                check("rty4_gap_rsp_valid", bus.rsp_valid, 0);
                tick();
            end
        end
        check("rty4_cyc", bus.wb_cyc_o, 0);
        check("rty4_rsp_valid", bus.rsp_valid, 1);
        check("rty4_status", bus.rsp_status, 2);
        check("rty4_rsp_dat", bus.rsp_dat, 0);
        tick();

        // Silent slave: stb high for 6 cycles, then TIMEOUT.
        issue(1'b0, 32'h0000_0030, 32'h0, 4'hF);
        for (int c = 0; c < 6; c++) begin
            check("to_stb_high", bus.wb_stb_o, 1);
            check("to_rsp_valid_low", bus.rsp_valid, 0);
            tick();
        end
        check("to_stb_low", bus.wb_stb_o, 0);
        check("to_rsp_valid", bus.rsp_valid, 1);
        check("to_status", bus.rsp_status, 3);
        check("to_rsp_dat", bus.rsp_dat, 0);
        tick();

        // err and ack together: err wins.
        issue(1'b0, 32'h0000_0034, 32'h0, 4'hF);
        term(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        check("errack_rsp_valid", bus.rsp_valid, 1);
        check("errack_status", bus.rsp_status, 1);
        check("errack_rsp_dat", bus.rsp_dat, 0);
        tick();

        // Response backpressure with a queued command.
        issue(1'b0, 32'h0000_0040, 32'h0, 4'hF);
        bus.rsp_ready = 1'b0;
        term(1'b1, 1'b0, 1'b0, 32'h7777_8888);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h0000_0044;
        bus.cmd_sel   = 4'hF;
        for (int c = 0; c < 10; c++) begin
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_dat", bus.rsp_dat, 32'h7777_8888);
            check("bp_status", bus.rsp_status, 0);
            check("bp_cmd_ready", bus.cmd_ready, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        check("bp_hs_rsp_valid", bus.rsp_valid, 1);
        tick();
        check("bp_after_rsp_valid", bus.rsp_valid, 0);
        check("bp_after_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        check("bp_queued_cyc", bus.wb_cyc_o, 1);
        check("bp_queued_adr", bus.wb_adr_o, 32'h0000_0044);
        term(1'b1, 1'b0, 1'b0, 32'h0000_0099);
        check("bp_queued_rsp_dat", bus.rsp_dat, 32'h0000_0099);
        tick();

        // Reset pulse mid-BUS: bus drops without waiting for an edge.
        issue(1'b1, 32'h0000_0050, 32'h1234_5678, 4'h3);
        check("rstbus_cyc_before", bus.wb_cyc_o, 1);
        wb_rst = 1'b1;
        #1;
        check("rstbus_cyc", bus.wb_cyc_o, 0);
        check("rstbus_stb", bus.wb_stb_o, 0);
        check("rstbus_we", bus.wb_we_o, 0);
        check("rstbus_adr", bus.wb_adr_o, 0);
        check("rstbus_dat", bus.wb_dat_o, 0);
        check("rstbus_sel", bus.wb_sel_o, 0);
        check("rstbus_cmd_ready", bus.cmd_ready, 1);
        tick();
        wb_rst = 1'b0;

        // Reset pulse mid-RESP (after an ERR response).
        issue(1'b0, 32'h0000_0054, 32'h0, 4'hF);
        bus.rsp_ready = 1'b0;
        term(1'b0, 1'b1, 1'b0, 32'h0);
        check("rstrsp_rsp_valid_before", bus.rsp_valid, 1);
        check("rstrsp_status_before", bus.rsp_status, 1);
        wb_rst = 1'b1;
        #1;
        check("rstrsp_rsp_valid", bus.rsp_valid, 0);
        check("rstrsp_status", bus.rsp_status, 0);
        check("rstrsp_state", dbg_state, S_IDLE);
        tick();
        wb_rst = 1'b0;
        bus.rsp_ready = 1'b1;

        // Normal read after the resets.
        issue(1'b0, 32'h0000_0060, 32'h0, 4'hF);
        check("post_cyc", bus.wb_cyc_o, 1);
        check("post_adr", bus.wb_adr_o, 32'h0000_0060);
        tick();
        term(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        check("post_rsp_valid", bus.rsp_valid, 1);
        check("post_rsp_dat", bus.rsp_dat, 32'hDEAD_BEEF);
        check("post_status", bus.rsp_status, 0);
        check("post_state", dbg_state, S_RESP);
        tick();
        check("post_idle", dbg_state, S_IDLE);
        check("post_bus_state_seen", {30'h0, S_BUS}, 32'h1 & {30'h0, S_BUS});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Single-outstanding Wishbone B3 classic master that turns a valid/ready command stream into bus cycles on the platform Wishbone bus. It sits directly upstream of the bus slaves (syscon register file and peers), so a debug bridge or CPU-less test harness can issue reads and writes. It also handles slave error, retry and timeout termination, and returns one response per command on a valid/ready response channel.

## Interface
- AW, 32: address width.
- DW, 32: data width; byte selects are DW/8 bits wide.
- TIMEOUT_CYCLES, 255: maximum cycles one attempt may wait for ack/err/rty; 0 disables the timeout.
- MAX_RETRIES, 3: number of re-issues after rty before giving up.

Ports:
- wb_clk  in  1  clock.
- wb_rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid at a rising edge.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  AW  byte address.
- cmd_dat  in  DW  write data.
- cmd_sel  in  DW/8  byte enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_dat  out  DW  read data.
- rsp_status  out  2  0 = OK, 1 = ERR, 2 = RETRY exhausted, 3 = TIMEOUT.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone cycle, strobe and write-enable.
- wb_adr_o  out  AW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_sel_o  out  DW/8  Wishbone byte selects.
- wb_dat_i  in  DW  Wishbone read data.
- wb_ack_i, wb_err_i, wb_rty_i  in  1  Wishbone termination inputs.

## Operation
- States:
  - IDLE: cmd_ready = 1.
  - BUS: cyc = stb = 1.
  - GAP: one-cycle bus release between retries.
  - RESP: rsp_valid = 1.
- IDLE → BUS on cmd handshake. cmd_we/adr/dat/sel are latched into the wb_*_o registers and held stable for the whole command, retries included. The retry counter and timeout counter clear.
- In BUS, terminations are sampled each edge with priority err > ack > rty:
  - err → RESP with status ERR.
  - ack → RESP with status OK; wb_dat_i is captured into rsp_dat on reads.
  - rty with retries < MAX_RETRIES → GAP; retries increments.
  - rty with retries == MAX_RETRIES → RESP with status RETRY.
  - No termination: the timeout counter increments. When it reaches TIMEOUT_CYCLES (nonzero) → RESP with status TIMEOUT.
- GAP → BUS unconditionally. The timeout counter clears on every entry to BUS.
- RESP → IDLE on rsp_ready. rsp_dat and rsp_status hold stable while rsp_valid is high.
- rsp_dat is 0 for writes and for any non-OK status.
- wb_cyc_o and wb_stb_o are always equal and registered. They fall on the edge that samples the termination.
- Termination inputs arriving outside BUS are ignored.
- The counters saturate and never wrap. The timeout counter width is clog2(TIMEOUT_CYCLES+1); the retry counter width is clog2(MAX_RETRIES+1).
- Reset, asynchronously and also mid-transaction:
  - State goes to IDLE.
  - wb_cyc_o = wb_stb_o = wb_we_o = 0; wb_adr_o, wb_dat_o, wb_sel_o = 0.
  - rsp_valid = 0, rsp_dat = 0, rsp_status = 0, counters = 0.
  - cmd_ready = 1 (it is decoded from IDLE); a command is accepted only on an edge where wb_rst is low.

## Timing
- Cycle 0: cmd handshake. Cycle 1: cyc/stb high.
- For a slave with registered ack (ack one cycle after stb), ack is high in cycle 2. Cycle 3: cyc/stb low, rsp_valid high.
- Command-to-response latency is 3 cycles.
- With rsp_ready held high, throughput is one command per 4 cycles: IDLE is revisited for one cycle before the next accept.
- A retry costs 2 cycles: the rty sample edge, then GAP, then BUS again.
- A timeout asserts rsp_valid TIMEOUT_CYCLES+1 cycles after stb rises.
- The master holds stb only until the first termination edge. Therefore a slave that keeps ack high while stb stays high still produces exactly one ack per access.
- There is no combinational path from any Wishbone input to any output. The only input-to-output combinational path is none: cmd_ready depends on state only.

## Test plan
- Read, ack at latency 1, slave data 0x0C0B_000A: rsp_valid in cycle 3, rsp_dat = 0x0C0B_000A, status 0; cyc high for exactly 2 cycles.
- Write adr 0x08, dat 0xA5A5_5A5A, sel 0x1: the slave sees adr/dat/sel/we stable for the whole cycle; status 0, rsp_dat = 0.
- Slave asserts rty 3 times, then ack: 4 BUS phases separated by 1-cycle gaps, status OK. With 4 rty: status 2 after the 4th rty.
- Slave never responds, TIMEOUT_CYCLES = 5: stb high for 6 cycles, then status 3; err and ack asserted in the same cycle → status 1.
- Response backpressure: rsp_ready low for 10 cycles, then high. rsp_* stays stable, cmd_ready stays low until the cycle after the rsp handshake, and a queued cmd_valid is accepted then.
- wb_rst pulsed mid-BUS and mid-RESP: cyc/stb/rsp_valid drop immediately (asynchronously); the next command completes normally with correct data.
